// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle lane generator: default modulus and
// coefficient width, the controller state encoding and the lane-root table.
// Lane roots are powers of the primitive 256th root of unity 17 mod 3329:
// R_k = 17^(128*k/LANES), so LANES=2 gives {1, 1729} and LANES=4 gives
// {1, 17^32, 17^64, 17^96} = {1, 2580, 1729, 3289}.
package twiddle_pkg;

  localparam int Q_DEF = 3329;
  localparam int W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Row 0: LANES=1, row 1: LANES=2, row 2: LANES=4. Unused entries are 0.
  localparam int unsigned LANE_ROOT [3][4] = '{
    '{1, 0,    0,    0   },
    '{1, 1729, 0,    0   },
    '{1, 2580, 1729, 3289}
  };

  // Root multiplier for lane k of a LANES-wide beat.
  function automatic int unsigned lane_root(input int lanes, input int k);
    int          row;
    logic [1:0]  row_sel;
    logic [1:0]  k_sel;
    row     = (lanes >= 4) ? 2 : ((lanes == 2) ? 1 : 0);
    row_sel = row[1:0];
    k_sel   = k[1:0];
    return LANE_ROOT[row_sel][k_sel];
  endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier: p = a*b mod Q after exactly LAT clock edges.
// For LAT >= 2 the raw product is registered first and the reduction sits in
// the second stage; any remaining stages are plain delay. No handshake: the
// result of the operands presented in cycle t appears in cycle t+LAT.
module mod_mul_pipe #(
  parameter int W   = 12,
  parameter int Q   = 3329,
  parameter int LAT = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  localparam int              NRS = (LAT > 1) ? LAT - 1 : 1;
  localparam logic [2*W-1:0]  Q_P = (2*W)'(Q);

  logic [2*W-1:0] prod_full;
  logic [W-1:0]   red;
  logic [W-1:0]   pipe_d [NRS];
  logic [W-1:0]   pipe_q [NRS];

  assign prod_full = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  generate
    if (LAT > 1) begin : g_split
      logic [2*W-1:0] prod_q;
      // Stage 1: register the full-width product.
      always_ff @(posedge clock) begin
        if (reset) prod_q <= '0;
        else       prod_q <= prod_full;
      end
      assign red = W'(prod_q % Q_P);
    end else begin : g_direct
      assign red = W'(prod_full % Q_P);
    end
  endgenerate

  // Next value of the reduced-result shift chain.
  always_comb begin
    pipe_d[0] = red;
    for (int i = 1; i < NRS; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Reduced-result shift chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NRS; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < NRS; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign p = pipe_q[NRS-1];

endmodule

// File: rtl/twiddle_lane_gen.sv
// Twiddle-stream generator: walks w0, w0*s, w0*s^2, ... mod Q for `count`
// beats and presents each as LANES lane-rotated copies (lane k = w*R_k).
// Each beat costs one ISSUE cycle, MUL_LAT WAIT cycles and at least one OUT
// cycle; w_out is held until the consumer takes it.
// Optional feature macro: TWIDDLE_RANGE_CHECK_EN -- rejects a start whose
// w0 or step is >= Q and pulses err instead. Without it err is tied low.
module twiddle_lane_gen
  import twiddle_pkg::*;
#(
  parameter int Q       = Q_DEF,
  parameter int W       = W_DEF,
  parameter int LANES   = 2,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [W-1:0]       w0,
  input  logic [W-1:0]       step,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] w_out,
  output logic               done,
  output logic               err
);

  localparam int               WC_W      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MUL_LAT - 1);

  state_e               state_d,    state_q;
  logic [W-1:0]         w_d,        w_q;
  logic [W-1:0]         s_d,        s_q;
  logic [W-1:0]         w_next_d,   w_next_q;
  logic [CNT_W-1:0]     rem_d,      rem_q;
  logic [WC_W-1:0]      wait_cnt_d, wait_cnt_q;
  logic [LANES*W-1:0]   w_out_d,    w_out_q;
  logic                 done_d,     done_q;

  logic [W-1:0]         prod [LANES];
  logic [LANES*W-1:0]   lane_vec;
  logic                 start_bad;

  // Multiplier 0 advances the sequence (w*s); multipliers 1..LANES-1 form
  // the rotated lanes. Lane 0 needs no product and is w itself.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_step
        mod_mul_pipe #(.W(W), .Q(Q), .LAT(MUL_LAT)) u_mul (
          .clock (clock),
          .reset (reset),
          .a     (w_q),
          .b     (s_q),
          .p     (prod[gi])
        );
        assign lane_vec[gi*W +: W] = w_q;
      end else begin : g_root
        localparam logic [W-1:0] ROOT = W'(lane_root(LANES, gi));
        mod_mul_pipe #(.W(W), .Q(Q), .LAT(MUL_LAT)) u_mul (
          .clock (clock),
          .reset (reset),
          .a     (w_q),
          .b     (ROOT),
          .p     (prod[gi])
        );
        assign lane_vec[gi*W +: W] = prod[gi];
      end
    end
  endgenerate

`ifdef TWIDDLE_RANGE_CHECK_EN
  localparam logic [W-1:0] Q_W = W'(Q);
  logic err_d, err_q;
  assign start_bad = (w0 >= Q_W) || (step >= Q_W);
`else
  assign start_bad = 1'b0;
`endif

  // Next-state and datapath control for IDLE -> ISSUE -> WAIT -> OUT.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    s_d        = s_q;
    w_next_d   = w_next_q;
    rem_d      = rem_q;
    wait_cnt_d = wait_cnt_q;
    w_out_d    = w_out_q;
    done_d     = 1'b0;
`ifdef TWIDDLE_RANGE_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_bad) begin
`ifdef TWIDDLE_RANGE_CHECK_EN
            err_d = 1'b1;
`endif
          end else if (count == '0) begin
            done_d = 1'b1;
          end else begin
            w_d     = w0;
            s_d     = step;
            rem_d   = count;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = WAIT_LAST;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Products of the operands seen in ISSUE land on the last WAIT cycle.
        if (wait_cnt_q == '0) begin
          w_out_d  = lane_vec;
          w_next_d = prod[0];
          state_d  = ST_OUT;
        end else begin
          wait_cnt_d = wait_cnt_q - WC_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_d   = w_next_q;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      s_q        <= '0;
      w_next_q   <= '0;
      rem_q      <= '0;
      wait_cnt_q <= '0;
      w_out_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      s_q        <= s_d;
      w_next_q   <= w_next_d;
      rem_q      <= rem_d;
      wait_cnt_q <= wait_cnt_d;
      w_out_q    <= w_out_d;
      done_q     <= done_d;
    end
  end

`ifdef TWIDDLE_RANGE_CHECK_EN
  // One-cycle error pulse for a rejected start.
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign w_out     = w_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_twiddle_lane_gen.sv
// Self-checking bench for twiddle_lane_gen (Q=3329, W=12, LANES=2, MUL_LAT=3).
// Expected beats come from a plain-arithmetic model: w_i = w0*s^i mod Q and
// lane k = w_i * 17^(128k/LANES) mod Q.
module tb_twiddle_lane_gen;

  localparam int Q       = 3329;
  localparam int W       = 12;
  localparam int LANES   = 2;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [W-1:0]       w0;
  logic [W-1:0]       step;
  logic [CNT_W-1:0]   count;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] w_out;
  logic               done;
  logic               err;

  int checks = 0;
  int errors = 0;

  logic [LANES*W-1:0] got_w[$];
  int                 got_cyc[$];
  int done_cyc, done_cnt, err_cnt, first_valid, valid_drop, hold_bad, busy_seen, busy_at_done;
  bit timed_out;

  always #5 clock = ~clock;

  twiddle_lane_gen #(.Q(Q), .W(W), .LANES(LANES), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .w0        (w0),
    .step      (step),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w_out     (w_out),
    .done      (done),
    .err       (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic longint modpow(longint b, int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic logic [LANES*W-1:0] model_beat(longint a0, longint st, int i);
    logic [LANES*W-1:0] v;
    longint w = a0 % Q;
    for (int j = 0; j < i; j++) w = (w * st) % Q;
    for (int k = 0; k < LANES; k++) v[k*W +: W] = W'((w * modpow(17, 128 * k / LANES)) % Q);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one start at cycle 0 and acts as consumer; records beats and events.
  task automatic run_seq(input logic [W-1:0] a0, input logic [W-1:0] st, input logic [CNT_W-1:0] cnt,
                         input int stall_beat, input int stall_len, input bit rnd, input bit poke,
                         input int budget);
    int stalled = 0;
    bit prev_pend = 0;
    bit poked = 0;
    logic [LANES*W-1:0] prev_w = '0;
    got_w.delete();
    got_cyc.delete();
    done_cyc = -1; done_cnt = 0; err_cnt = 0; first_valid = -1; valid_drop = 0;
    hold_bad = 0; busy_seen = 0; busy_at_done = 0; timed_out = 1;
    start = 1'b1; w0 = a0; step = st; count = cnt;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) start = 1'b0;
      if (poke && !poked && out_valid && got_w.size() == 1) begin
        start = 1'b1; w0 = W'($urandom_range(0, Q - 1)); step = W'($urandom_range(0, Q - 1));
        count = 8'd9; poked = 1;
      end
      if (out_valid && got_w.size() == stall_beat && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else if (rnd) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      if (prev_pend) begin
        if (!out_valid) valid_drop++;
        else if (w_out !== prev_w) hold_bad++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (busy && cyc > 0) busy_seen++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = int'(busy); end
      end
      if (out_valid && out_ready) begin got_w.push_back(w_out); got_cyc.push_back(cyc); end
      prev_pend = out_valid && !out_ready;
      prev_w = w_out;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin timed_out = 0; break; end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; w0 = '0; step = '0; count = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (w_out !== '0) begin errors++; $display("FAIL reset_wout got %h want 0", w_out); end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_sequence();
    logic [LANES*W-1:0] exp_lit [3];
    exp_lit[0] = {12'd1729, 12'd1};
    exp_lit[1] = {12'd2761, 12'd17};
    exp_lit[2] = {12'd331,  12'd289};
    run_seq(12'd1, 12'd17, 8'd3, -1, 0, 0, 0, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL seq_timeout got no done want done"); end
    checks++; if (got_w.size() != 3) begin errors++; $display("FAIL seq_beats got %0d want 3", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 3; i++) begin
      checks++;
      if (got_w[i] !== exp_lit[i]) begin errors++; $display("FAIL seq_beat%0d got %h want %h", i, got_w[i], exp_lit[i]); end
      checks++;
      if (got_cyc[i] != 5 + 5 * i) begin errors++; $display("FAIL seq_cycle%0d got %0d want %0d", i, got_cyc[i], 5 + 5 * i); end
    end
    checks++; if (first_valid != MUL_LAT + 2) begin errors++; $display("FAIL seq_first_valid got %0d want %0d", first_valid, MUL_LAT + 2); end
    checks++; if (done_cyc != 16) begin errors++; $display("FAIL seq_done_cycle got %0d want 16", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL seq_done_count got %0d want 1", done_cnt); end
    checks++; if (busy_at_done != 0) begin errors++; $display("FAIL seq_busy_at_done got %0d want 0", busy_at_done); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL seq_err got %0d want 0", err_cnt); end
    $display("test_sequence: w0=1 step=17 count=3 beats=%0d done_cycle=%0d", got_w.size(), done_cyc);
  endtask

  task automatic test_backpressure();
    run_seq(12'd1, 12'd17, 8'd3, 1, 10, 0, 0, 100);
    checks++; if (got_w.size() != 3) begin errors++; $display("FAIL bp_beats got %0d want 3", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 3; i++) begin
      checks++;
      if (got_w[i] !== model_beat(1, 17, i)) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, got_w[i], model_beat(1, 17, i)); end
    end
    if (got_cyc.size() > 1) begin
      checks++; if (got_cyc[1] != 20) begin errors++; $display("FAIL bp_beat2_cycle got %0d want 20", got_cyc[1]); end
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", hold_bad); end
    checks++; if (valid_drop != 0) begin errors++; $display("FAIL bp_valid_drop got %0d want 0", valid_drop); end
    checks++; if (done_cyc != 26) begin errors++; $display("FAIL bp_done_cycle got %0d want 26", done_cyc); end
    $display("test_backpressure: 10-cycle stall at beat 2, beats=%0d done_cycle=%0d", got_w.size(), done_cyc);
  endtask

  task automatic test_count_zero();
    run_seq(12'd5, 12'd7, 8'd0, -1, 0, 0, 0, 30);
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL cz_done_cycle got %0d want 1", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cz_done_count got %0d want 1", done_cnt); end
    checks++; if (first_valid != -1) begin errors++; $display("FAIL cz_valid got cycle %0d want never", first_valid); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL cz_busy got %0d cycles want 0", busy_seen); end
    $display("test_count_zero: done_cycle=%0d", done_cyc);
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; start = 1'b1; w0 = 12'd1; step = 12'd17; count = 8'd3; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin tick(); start = 1'b0; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", out_valid); end
    checks++; if (w_out !== '0) begin errors++; $display("FAIL rm_wout got %h want 0", w_out); end
    tick(); tick();
    run_seq(12'd1, 12'd17, 8'd3, -1, 0, 0, 0, 100);
    checks++; if (got_w.size() != 3) begin errors++; $display("FAIL rm_beats got %0d want 3", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 3; i++) begin
      checks++;
      if (got_w[i] !== model_beat(1, 17, i)) begin errors++; $display("FAIL rm_beat%0d got %h want %h", i, got_w[i], model_beat(1, 17, i)); end
    end
    checks++; if (first_valid != 5) begin errors++; $display("FAIL rm_first_valid got %0d want 5", first_valid); end
    $display("test_reset_mid: reset in WAIT of beat 2, rerun beats=%0d", got_w.size());
  endtask

  task automatic test_start_in_out();
    run_seq(12'd3, 12'd1000, 8'd4, -1, 0, 0, 1, 100);
    checks++; if (got_w.size() != 4) begin errors++; $display("FAIL sio_beats got %0d want 4", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 4; i++) begin
      checks++;
      if (got_w[i] !== model_beat(3, 1000, i)) begin errors++; $display("FAIL sio_beat%0d got %h want %h", i, got_w[i], model_beat(3, 1000, i)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL sio_done_count got %0d want 1", done_cnt); end
    $display("test_start_in_out: start pulsed in OUT, beats=%0d", got_w.size());
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      logic [W-1:0] a0, st;
      logic [CNT_W-1:0] cnt;
      a0 = W'($urandom_range(0, Q - 1));
      st = W'($urandom_range(0, Q - 1));
      cnt = CNT_W'($urandom_range(1, 6));
      run_seq(a0, st, cnt, -1, 0, 1, 0, 500);
      checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout got no done want done", t); end
      checks++; if (got_w.size() != int'(cnt)) begin errors++; $display("FAIL rnd%0d_beats got %0d want %0d", t, got_w.size(), cnt); end
      for (int i = 0; i < got_w.size(); i++) begin
        checks++;
        if (got_w[i] !== model_beat(longint'(a0), longint'(st), i)) begin
          errors++; $display("FAIL rnd%0d_beat%0d got %h want %h", t, i, got_w[i], model_beat(longint'(a0), longint'(st), i));
        end
      end
      checks++; if (hold_bad != 0 || valid_drop != 0) begin errors++; $display("FAIL rnd%0d_hold got %0d/%0d want 0/0", t, hold_bad, valid_drop); end
      checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL rnd%0d_done_err got %0d/%0d want 1/0", t, done_cnt, err_cnt); end
      $display("test_random[%0d]: w0=%0d step=%0d count=%0d beats=%0d", t, a0, st, cnt, got_w.size());
    end
  endtask

`ifdef TWIDDLE_RANGE_CHECK_EN
  task automatic test_range_check();
    run_seq(12'd3329, 12'd17, 8'd3, -1, 0, 0, 0, 12);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL rc_err got %0d pulses want 1", err_cnt); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL rc_busy got %0d cycles want 0", busy_seen); end
    checks++; if (got_w.size() != 0) begin errors++; $display("FAIL rc_beats got %0d want 0", got_w.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rc_done got %0d want 0", done_cnt); end
    run_seq(12'd5, 12'd4000, 8'd0, -1, 0, 0, 0, 12);
    checks++; if (err_cnt != 1 || done_cnt != 0) begin errors++; $display("FAIL rc_cz got err %0d done %0d want 1 0", err_cnt, done_cnt); end
    $display("test_range_check: out-of-range starts rejected");
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_count_zero();
    test_reset_mid();
    test_start_in_out();
`ifdef TWIDDLE_RANGE_CHECK_EN
    test_range_check();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
